// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst helpers for the arbiter and slave interface.
package ahb_pkg;

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'd0;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'd1;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'd3;

  localparam logic [2:0] AHB_BURST_SINGLE = 3'd0;
  localparam logic [2:0] AHB_BURST_INCR   = 3'd1;
  localparam logic [2:0] AHB_BURST_WRAP4  = 3'd2;
  localparam logic [2:0] AHB_BURST_INCR4  = 3'd3;
  localparam logic [2:0] AHB_BURST_WRAP8  = 3'd4;
  localparam logic [2:0] AHB_BURST_INCR8  = 3'd5;
  localparam logic [2:0] AHB_BURST_WRAP16 = 3'd6;
  localparam logic [2:0] AHB_BURST_INCR16 = 3'd7;

  // Undefined-length INCR counts as a single beat: it never pins the bus.
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst)
      AHB_BURST_WRAP4,  AHB_BURST_INCR4:  burst_beats = 5'd4;
      AHB_BURST_WRAP8,  AHB_BURST_INCR8:  burst_beats = 5'd8;
      AHB_BURST_WRAP16, AHB_BURST_INCR16: burst_beats = 5'd16;
      default:                            burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first request found after the last winner.
module ahb_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          last,
  output logic [MW-1:0]          winner,
  output logic                   valid
);

  logic [MW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = MW'((32'(last) + i) % NUM_MASTERS);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Multi-master AHB arbiter: round-robin grants, burst/lock protection,
// default-master parking and registered address/data owner indices.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   ahb_clk_in,
  input  logic                   ahb_rstn_in,
  input  logic [NUM_MASTERS-1:0] ahb_busreq_in,
  input  logic [NUM_MASTERS-1:0] ahb_lock_in,
  input  logic [1:0]             ahb_trans_in,
  input  logic [2:0]             ahb_burst_in,
  input  logic                   ahb_ready_in,
  output logic [NUM_MASTERS-1:0] ahb_grant_out,
  output logic [MW-1:0]          ahb_master_out,
  output logic [MW-1:0]          ahb_master_data_out,
  output logic                   ahb_mastlock_out
);

  localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          grant_idx_q, rr_last_q, master_q, master_data_q;
  logic [MW-1:0]          pick_idx, win_idx;
  logic                   pick_valid, win_real, owner_locked;
  logic                   arb_point, lock_hold_q;
  logic [3:0]             beat_cnt_q;

  ahb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .MW          (MW)
  ) u_picker (
    .req    (ahb_busreq_in),
    .last   (rr_last_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    arb_point = 1'b0;
    if (ahb_ready_in && !lock_hold_q) begin
      case (ahb_trans_in)
        AHB_TRANS_IDLE:   arb_point = 1'b1;
        AHB_TRANS_NONSEQ: arb_point = (ahb_burst_in == AHB_BURST_SINGLE) ||
                                      (ahb_burst_in == AHB_BURST_INCR);
        AHB_TRANS_SEQ:    arb_point = (ahb_burst_in == AHB_BURST_INCR) ||
                                      (beat_cnt_q == 4'd1);
        default:          arb_point = 1'b0;
      endcase
    end
  end

  // A locking owner that still requests keeps the bus ahead of round-robin.
  always_comb begin
    owner_locked = ahb_lock_in[master_q] && ahb_busreq_in[master_q];
    win_real     = owner_locked || pick_valid;
    if (owner_locked)    win_idx = master_q;
    else if (pick_valid) win_idx = pick_idx;
    else                 win_idx = DEF_IDX;
    grant_d          = '0;
    grant_d[win_idx] = 1'b1;
  end

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      grant_q       <= DEF_GRANT;
      grant_idx_q   <= DEF_IDX;
      rr_last_q     <= DEF_IDX;
      master_q      <= DEF_IDX;
      master_data_q <= DEF_IDX;
      lock_hold_q   <= 1'b0;
      beat_cnt_q    <= '0;
    end else begin
      if (arb_point) begin
        grant_q     <= grant_d;
        grant_idx_q <= win_idx;
        if (win_real) rr_last_q <= win_idx;
      end
      if (ahb_ready_in) begin
        master_q      <= grant_idx_q;
        master_data_q <= master_q;
        case (ahb_trans_in)
          AHB_TRANS_NONSEQ: beat_cnt_q <= 4'(burst_beats(ahb_burst_in) - 5'd1);
          AHB_TRANS_SEQ:    if (beat_cnt_q != '0) beat_cnt_q <= beat_cnt_q - 4'd1;
          AHB_TRANS_IDLE:   beat_cnt_q <= '0;
          default:          beat_cnt_q <= beat_cnt_q;
        endcase
        if (ahb_trans_in == AHB_TRANS_NONSEQ && ahb_lock_in[master_q])
          lock_hold_q <= 1'b1;
        else if (!ahb_lock_in[master_q] &&
                 (ahb_trans_in == AHB_TRANS_IDLE || ahb_trans_in == AHB_TRANS_NONSEQ))
          lock_hold_q <= 1'b0;
      end
    end
  end

  assign ahb_grant_out       = grant_q;
  assign ahb_master_out      = master_q;
  assign ahb_master_data_out = master_data_q;
  assign ahb_mastlock_out    = lock_hold_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: hand-computed grants/owners per clock edge.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] busreq, lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready;
  logic [3:0] grant;
  logic [1:0] master, master_data;
  logic       mastlock;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ahb_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .ahb_clk_in          (clk),
    .ahb_rstn_in         (rstn),
    .ahb_busreq_in       (busreq),
    .ahb_lock_in         (lock),
    .ahb_trans_in        (trans),
    .ahb_burst_in        (burst),
    .ahb_ready_in        (ready),
    .ahb_grant_out       (grant),
    .ahb_master_out      (master),
    .ahb_master_data_out (master_data),
    .ahb_mastlock_out    (mastlock)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic [2:0] b, input logic [3:0] rq,
                       input logic [3:0] lk, input logic rdy);
    trans = t; burst = b; busreq = rq; lock = lk; ready = rdy;
  endtask

  initial begin
    rstn = 1'b0;
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b0000, 4'b0000, 1'b1);
    step(3);
    chk("rst_grant", grant, 4'b0001);
    chk("rst_master", master, 0);
    chk("rst_data", master_data, 0);
    chk("rst_lock", mastlock, 0);
    rstn = 1'b1;

    // M2 alone, then a SINGLE transfer; park back on M0 when requests stop
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b0100, 4'b0000, 1'b1);
    step();
    chk("s1_grant", grant, 4'b0100);
    chk("s1_master_lag", master, 0);
    step();
    chk("s1_master", master, 2);
    chk("s1_data_lag", master_data, 0);
    drive(AHB_TRANS_NONSEQ, AHB_BURST_SINGLE, 4'b0100, 4'b0000, 1'b1);
    step();
    chk("s1_data", master_data, 2);
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b0000, 4'b0000, 1'b1);
    step();
    chk("park_grant", grant, 4'b0001);
    step();
    chk("park_master", master, 0);

    // M1 INCR4, M3 requests on beat 1: handover at beat-4 address edge
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b0010, 4'b0000, 1'b1);
    step(2);
    chk("s2_own", master, 1);
    drive(AHB_TRANS_NONSEQ, AHB_BURST_INCR4, 4'b1010, 4'b0000, 1'b1);
    step();
    chk("s2_beat1", grant, 4'b0010);
    trans = AHB_TRANS_SEQ;
    step(2);
    chk("s2_beat3", grant, 4'b0010);
    step();
    chk("s2_handover", grant, 4'b1000);
    chk("s2_data", master_data, 1);
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b1000, 4'b0000, 1'b1);
    step();
    chk("s2_master", master, 3);

    // Same burst with 3 wait states on beat 2
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b0010, 4'b0000, 1'b1);
    step();
    chk("s3_grant", grant, 4'b0010);
    step();
    chk("s3_own", master, 1);
    drive(AHB_TRANS_NONSEQ, AHB_BURST_INCR4, 4'b1010, 4'b0000, 1'b1);
    step();
    drive(AHB_TRANS_SEQ, AHB_BURST_INCR4, 4'b1010, 4'b0000, 1'b0);
    step(3);
    chk("s3_wait_grant", grant, 4'b0010);
    chk("s3_wait_data", master_data, 1);
    ready = 1'b1;
    step(2);
    chk("s3_beat3", grant, 4'b0010);
    step();
    chk("s3_handover", grant, 4'b1000);

    // Park rr_last on M0, then all four request SINGLE continuously
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b0001, 4'b0000, 1'b1);
    step();
    chk("s4_seed", grant, 4'b0001);
    drive(AHB_TRANS_NONSEQ, AHB_BURST_SINGLE, 4'b1111, 4'b0000, 1'b1);
    step(); chk("rr_1", grant, 4'b0010);
    step(); chk("rr_2", grant, 4'b0100);
    step(); chk("rr_3", grant, 4'b1000);
    step(); chk("rr_4", grant, 4'b0001);
    step(); chk("rr_5", grant, 4'b0010);

    // M2 locked, two INCR8 bursts back-to-back while M0 waits
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b0100, 4'b0100, 1'b1);
    step(2);
    chk("s5_grant", grant, 4'b0100);
    chk("s5_own", master, 2);
    drive(AHB_TRANS_NONSEQ, AHB_BURST_INCR8, 4'b0101, 4'b0100, 1'b1);
    step();
    chk("s5_mastlock", mastlock, 1);
    trans = AHB_TRANS_SEQ;
    step(7);
    chk("s5_burst1_end", grant, 4'b0100);
    trans = AHB_TRANS_NONSEQ;
    step();
    trans = AHB_TRANS_SEQ;
    step(7);
    chk("s5_burst2_grant", grant, 4'b0100);
    chk("s5_burst2_lock", mastlock, 1);
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b0001, 4'b0000, 1'b1);
    step();
    chk("s5_unlock", mastlock, 0);
    chk("s5_unlock_grant", grant, 4'b0100);
    step();
    chk("s5_m0_grant", grant, 4'b0001);
    step();
    chk("s5_m0_master", master, 0);

    // Async reset in the middle of a locked, stalled burst
    drive(AHB_TRANS_IDLE, AHB_BURST_SINGLE, 4'b0100, 4'b0100, 1'b1);
    step(2);
    drive(AHB_TRANS_NONSEQ, AHB_BURST_INCR4, 4'b0100, 4'b0100, 1'b1);
    step();
    chk("r_pre_lock", mastlock, 1);
    chk("r_pre_data", master_data, 2);
    drive(AHB_TRANS_SEQ, AHB_BURST_INCR4, 4'b0100, 4'b0100, 1'b0);
    #3 rstn = 1'b0;
    #1;
    chk("r_grant", grant, 4'b0001);
    chk("r_master", master, 0);
    chk("r_data", master_data, 0);
    chk("r_lock", mastlock, 0);
    step();
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
